// File: rtl/score_tx_if.sv
// Score line bundle between goal detection and the score transmitter.
// master = game logic side, slave = score_tx.
interface score_tx_if #(
  parameter int PEND_W = 4
);
  logic              goal;
  logic              score;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output goal,
    input  score,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  goal,
    output score,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/score_tx.sv
// score_tx: queues goal strobes, emits one HOLD-high/GAP-low pulse per point.
// Define SCORE_TX_OVF_EN to enable the sticky dropped-goal overflow flag.
module score_tx #(
  parameter int HOLD   = 600_000,
  parameter int GAP    = 600_000,
  parameter int CNT_W  = 20,
  parameter int PEND_W = 4
) (
  input  logic     clk25,
  input  logic     reset,
  score_tx_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              score_q, score_d;

  logic cnt_zero;
  logic pend_nz;
  logic start;
  logic dec;
  logic direct;
  logic drop;
  logic acc;

  always_comb begin
    cnt_zero = (cnt_q == '0);
    pend_nz  = (pend_q != '0);
    start    = ((state_q == S_IDLE) ||
                ((state_q == S_GAP) && cnt_zero)) &&
               (pend_nz || bus.goal);
    dec      = start && pend_nz;
    // A goal that starts a pulse from an empty queue never enters it.
    direct   = start && !pend_nz;
    drop     = bus.goal && (pend_q == PEND_MAX) && !dec;
    acc      = bus.goal && !direct && !drop;
  end

  always_comb begin
    pend_d = pend_q;
    if (acc && !dec)
      pend_d = pend_q + PEND_ONE;
    else if (dec && !acc)
      pend_d = pend_q - PEND_ONE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = S_HOLD;
      cnt_d   = HOLD_LD;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_zero) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_zero) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    score_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      score_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      score_q <= score_d;
    end
  end

`ifdef SCORE_TX_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.score   = score_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_score_tx.sv
// tb_score_tx: directed test-plan scenarios plus random goals/resets,
// checked every cycle against a pulse-timeline reference model.
module tb_score_tx;

  localparam int HOLD   = 4;
  localparam int GAP    = 3;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic clk25 = 1'b0;
  logic reset = 1'b1;

  score_tx_if #(.PEND_W(PEND_W)) bus ();

  score_tx #(
    .HOLD   (HOLD),
    .GAP    (GAP),
    .CNT_W  (3),
    .PEND_W (PEND_W)
  ) dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #20 clk25 = ~clk25;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // reference model: queued points and start cycle of the latest pulse
  int m_pend  = 0;
  int m_ps    = -100;
  bit m_ovf   = 1'b0;
  int m_start = 0;

  int   rises  = 0;
  logic prev_sc = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                tag, cyc, obs, exp);
  endtask

  task automatic step(input logic g, input logic r);
    int  tot;
    bit  free;
    bit  e_sc;
    bit  e_bz;
    bit  e_ov;
    e_sc = (cyc >= m_ps) && (cyc < m_ps + HOLD);
    e_bz = (cyc >= m_ps) && (cyc < m_ps + HOLD + GAP);
`ifdef SCORE_TX_OVF_EN
    e_ov = m_ovf;
`else
    e_ov = 1'b0;
`endif
    chk("score", int'(bus.score), int'(e_sc));
    chk("busy", int'(bus.busy), int'(e_bz));
    chk("pending", int'(bus.pending), m_pend);
    chk("overflow", int'(bus.overflow), int'(e_ov));
    if (bus.score === 1'b1 && prev_sc === 1'b0) rises++;
    prev_sc = bus.score;

    bus.goal = g;
    reset    = r;
    if (r) begin
      m_pend = 0;
      m_ps   = -100;
      m_ovf  = 1'b0;
    end else begin
      tot  = m_pend + int'(g);
      free = (cyc >= m_ps + HOLD + GAP - 1);
      if (free && tot > 0) begin
        tot  = tot - 1;
        m_ps = cyc + 1;
        m_start++;
      end
      if (tot > PMAX) begin
        tot   = PMAX;
        m_ovf = 1'b1;
      end
      m_pend = tot;
    end
    @(posedge clk25);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  initial begin
    bus.goal = 1'b0;
    repeat (2) @(posedge clk25);
    #1;
    m_pend = 0;
    m_ps   = -100;
    m_ovf  = 1'b0;

    // 1: single goal
    step(1'b0, 1'b1);
    idle(9);
    step(1'b1, 1'b0);
    idle(12);

    // 2: three consecutive goals
    do_reset();
    idle(3);
    repeat (3) step(1'b1, 1'b0);
    idle(25);

    // 3: saturation and overflow; exactly four pulses
    do_reset();
    rises   = 0;
    m_start = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    idle(40);
    chk("pulses_s3", rises, 4);
    chk("model_pulses_s3", rises, m_start);

    // 4: reset mid-HOLD with two queued
    do_reset();
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(20);

    // 5: goal on last GAP cycle with empty queue
    do_reset();
    step(1'b1, 1'b0);
    idle(HOLD + GAP - 1);
    step(1'b1, 1'b0);
    idle(12);

    // random traffic, dense bursts and sparse stretches, rare resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int  dens;
      logic g;
      logic r;
      dens = ((i / 100) % 2 == 0) ? 3 : 1;
      g    = ($urandom_range(3, 0) < dens);
      r    = ($urandom_range(149, 0) == 0);
      step(g, r);
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
